// File: rtl/adc_capture_pkg.sv
// adc_capture_pkg: shared state encoding, register map and field positions for adc_capture_ctrl.
package adc_capture_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, SETTLE = 2'd1, RUN = 2'd2} state_t;
  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_DIV    = 2'd2;
  localparam logic [1:0] ADDR_CTRL   = 2'd3;
  localparam int ST_COUNT_W = 9;
  localparam int ST_EMPTY   = 9;
  localparam int ST_FULL    = 10;
  localparam int ST_OVF     = 11;
  localparam int ST_STATE   = 12;
  localparam int CTRL_CLR   = 31;
  function automatic logic [15:0] div_sanitize(input logic [15:0] w);
    return (w == 16'd0) ? 16'd1 : w;
  endfunction
endpackage

// File: rtl/adc_sync_fifo.sv
// adc_sync_fifo: single-clock show-ahead FIFO; a push while full only lands when a pop frees the slot.
module adc_sync_fifo #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign do_pop = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout = mem[rd_ptr];
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(do_push);
      rd_ptr <= rd_ptr + AW'(do_pop);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= din;
endmodule

// File: rtl/adc_capture_ctrl.sv
// adc_capture_ctrl: paced ADC sampling into a local FIFO while enabled, drained over Avalon-MM.
module adc_capture_ctrl
  import adc_capture_pkg::*;
#(
  parameter int ADC_WIDTH     = 12,
  parameter int DEPTH         = 16,
  parameter int SETTLE_CYCLES = 8,
  parameter int DIV_DEFAULT   = 50
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 adc_on,
  input  logic [ADC_WIDTH-1:0] adc_data,
  output logic                 adc_sample,
  input  logic [1:0]           address,
  input  logic                 chipselect,
  input  logic                 read_n,
  input  logic                 write_n,
  input  logic [31:0]          writedata,
  output logic [31:0]          readdata,
  output logic                 irq
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int SW = $clog2(SETTLE_CYCLES) + 1;
  state_t state;
  logic [SW-1:0] settle;
  logic [15:0] period, period_len, div_reg;
  logic [8:0] thresh;
  logic [CW-1:0] count;
  logic [ADC_WIDTH-1:0] dout;
  logic [31:0] status;
  logic overflow, full, empty, wr, pop, ovf_event, clr;
  assign wr = chipselect & ~write_n;
  assign pop = chipselect & ~read_n & (address == ADDR_DATA);
  assign ovf_event = adc_sample & full & ~(pop & ~empty);
  assign clr = wr & (address == ADDR_CTRL) & writedata[CTRL_CLR];
  adc_sync_fifo #(.WIDTH(ADC_WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .reset_n(reset_n),
    .push(adc_sample),
    .pop(pop),
    .din(adc_data),
    .dout(dout),
    .count(count),
    .full(full),
    .empty(empty)
  );
  // period_len latches div_reg only at a period start so DIV writes never cut a period short
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      settle <= '0;
      period <= '0;
      period_len <= 16'(DIV_DEFAULT);
      adc_sample <= 1'b0;
    end else if (!adc_on) begin
      state <= IDLE;
      settle <= '0;
      period <= '0;
      adc_sample <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state <= SETTLE;
          settle <= SW'(SETTLE_CYCLES - 1);
        end
        SETTLE:
          if (settle == '0) begin
            state <= RUN;
            period <= '0;
            period_len <= div_reg;
            adc_sample <= 1'b1;
          end else settle <= settle - 1'b1;
        RUN:
          if (period >= period_len - 16'd1) begin
            period <= '0;
            period_len <= div_reg;
            adc_sample <= 1'b1;
          end else begin
            period <= period + 16'd1;
            adc_sample <= 1'b0;
          end
        default: state <= IDLE;
      endcase
    end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      div_reg <= 16'(DIV_DEFAULT);
      thresh <= 9'(DEPTH / 2);
      overflow <= 1'b0;
      irq <= 1'b0;
    end else begin
      if (wr && address == ADDR_DIV) div_reg <= div_sanitize(writedata[15:0]);
      if (wr && address == ADDR_CTRL) thresh <= writedata[8:0];
      overflow <= ovf_event | (overflow & ~clr);
      irq <= (9'(count) >= thresh && thresh != '0) | overflow;
    end
  always_comb begin
    status = '0;
    status[ST_COUNT_W-1:0] = 9'(count);
    status[ST_EMPTY] = empty;
    status[ST_FULL] = full;
    status[ST_OVF] = overflow;
    status[ST_STATE +: 2] = state;
  end
  always_comb
    readdata = (address == ADDR_DATA)   ? (empty ? '0 : 32'(dout)) :
               (address == ADDR_STATUS) ? status :
               (address == ADDR_DIV)    ? {16'b0, div_reg} : {23'b0, thresh};
endmodule

// File: tb/tb_adc_capture_ctrl.sv
// tb_adc_capture_ctrl: directed checks of pacing, FIFO fill/drain, overflow and reset behaviour.
module tb_adc_capture_ctrl;
  logic clk = 1'b0, reset_n = 1'b1, adc_on = 1'b0;
  logic chipselect = 1'b0, read_n = 1'b1, write_n = 1'b1;
  logic [11:0] adc_data = '0;
  logic [1:0] address = '0;
  logic [31:0] writedata = '0, readdata, rd;
  logic adc_sample, irq;
  int total = 0, passed = 0;

  adc_capture_ctrl #(.ADC_WIDTH(12), .DEPTH(16), .SETTLE_CYCLES(8), .DIV_DEFAULT(50)) dut (
    .clk(clk), .reset_n(reset_n), .adc_on(adc_on), .adc_data(adc_data), .adc_sample(adc_sample),
    .address(address), .chipselect(chipselect), .read_n(read_n), .write_n(write_n),
    .writedata(writedata), .readdata(readdata), .irq(irq)
  );

  always #5 clk = ~clk;
  // ramp: each strobe captures the previous value plus one (first capture is 1)
  always @(negedge clk) if (adc_sample) adc_data = adc_data + 12'd1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic peek(input logic [1:0] a, output logic [31:0] d);
    address = a; chipselect = 1'b1; read_n = 1'b0;
    #1 d = readdata;
    chipselect = 1'b0; read_n = 1'b1;
    #1;
  endtask

  task automatic avs_read(input logic [1:0] a, output logic [31:0] d);
    address = a; chipselect = 1'b1; read_n = 1'b0;
    #1 d = readdata;
    @(posedge clk);
    #1 chipselect = 1'b0; read_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic avs_write(input logic [1:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(posedge clk);
    #1 chipselect = 1'b0; write_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #1 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    peek(2'd1, rd); chk("rst_status", rd, 32'h200);
    peek(2'd2, rd); chk("rst_div", rd, 32'd50);
    peek(2'd3, rd); chk("rst_thresh", rd, 32'd8);
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_strobe", 32'(adc_sample), 32'd0);
    avs_write(2'd2, 32'd0);
    peek(2'd2, rd); chk("div_zero", rd, 32'd1);
    avs_write(2'd2, 32'd4);
    peek(2'd2, rd); chk("div_four", rd, 32'd4);
    avs_write(2'd0, 32'hFFFF);
    peek(2'd1, rd); chk("ro_write", rd, 32'h200);

    adc_on = 1'b1;
    for (int k = 1; k <= 18; k++) begin
      tick();
      chk($sformatf("strobe_a%0d", k), 32'(adc_sample), 32'(k == 9 || k == 13 || k == 17));
      if (k == 1) begin peek(2'd1, rd); chk("st_settle", rd, 32'h1200); end
      if (k == 10) begin peek(2'd1, rd); chk("st_run1", rd, 32'h2001); end
    end
    adc_on = 1'b0;
    for (int j = 1; j <= 8; j++) begin
      tick();
      chk($sformatf("off_strobe%0d", j), 32'(adc_sample), 32'd0);
    end
    peek(2'd1, rd); chk("off_status", rd, 32'h0003);
    chk("off_irq", 32'(irq), 32'd0);
    for (int i = 1; i <= 3; i++) begin
      avs_read(2'd0, rd); chk($sformatf("ramp%0d", i), rd, 32'(i));
      peek(2'd1, rd); chk($sformatf("ramp_cnt%0d", i), rd, (i == 3) ? 32'h200 : 32'(3 - i));
    end
    avs_read(2'd0, rd); chk("empty_read", rd, 32'd0);
    peek(2'd1, rd); chk("empty_status", rd, 32'h200);

    adc_on = 1'b1;
    for (int k = 1; k <= 74; k++) begin
      tick();
      if (k <= 9) chk($sformatf("resettle%0d", k), 32'(adc_sample), 32'(k == 9));
      if (k == 70) begin
        peek(2'd1, rd); chk("full_status", rd, 32'h2410);
        chk("full_irq", 32'(irq), 32'd1);
      end
    end
    peek(2'd1, rd); chk("ovf_status", rd, 32'h2C10);
    chk("ovf_irq", 32'(irq), 32'd1);
    avs_read(2'd0, rd); chk("ovf_first", rd, 32'd4);
    avs_write(2'd3, 32'h8000_0000);
    peek(2'd1, rd); chk("clr_status", rd, 32'h200F);
    chk("irq_lag", 32'(irq), 32'd1);
    tick();
    chk("irq_clear", 32'(irq), 32'd0);
    chk("strobe_77", 32'(adc_sample), 32'd1);
    tick();
    peek(2'd1, rd); chk("refull", rd, 32'h2410);
    repeat (3) tick();
    chk("strobe_81", 32'(adc_sample), 32'd1);
    avs_read(2'd0, rd); chk("coinc_data", rd, 32'd5);
    peek(2'd1, rd); chk("coinc_status", rd, 32'h2410);
    adc_on = 1'b0;
    for (int i = 0; i < 16; i++) begin
      avs_read(2'd0, rd);
      chk($sformatf("drain%0d", i), rd, (i < 14) ? 32'(6 + i) : (i == 14) ? 32'd21 : 32'd22);
    end
    peek(2'd1, rd); chk("drained", rd, 32'h200);

    avs_write(2'd3, 32'd3);
    peek(2'd3, rd); chk("thresh3", rd, 32'd3);
    adc_on = 1'b1;
    for (int k = 1; k <= 29; k++) begin
      tick();
      if (k == 26) begin
        peek(2'd1, rd); chk("cnt5", rd, 32'h2005);
        chk("thr_irq", 32'(irq), 32'd1);
      end
    end
    chk("strobe_pre_rst", 32'(adc_sample), 32'd1);
    #2 reset_n = 1'b0;
    #1 chk("arst_strobe", 32'(adc_sample), 32'd0);
    chk("arst_irq", 32'(irq), 32'd0);
    peek(2'd1, rd); chk("arst_status", rd, 32'h200);
    reset_n = 1'b1;
    adc_on = 1'b0;
    peek(2'd2, rd); chk("arst_div", rd, 32'd50);
    peek(2'd3, rd); chk("arst_thresh", rd, 32'd8);
    tick();
    peek(2'd1, rd); chk("final_status", rd, 32'h200);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
